// File: rtl/tensor_mma_sequencer_pkg.sv
// Shared types and sizing for the tensor MMA sequencer: FSM state encoding,
// default lane count and warp-id width used across the issue path.
package tensor_mma_sequencer_pkg;

  localparam int NUM_THREAD = 4;
  localparam int DEPTH_WARP = 4;

  localparam int EXPWIDTH_DEFAULT  = 8;
  localparam int PRECISION_DEFAULT = 24;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } seq_state_e;

  function automatic int fp_width(input int expwidth, input int precision);
    return expwidth + precision;
  endfunction

endpackage

// File: rtl/tensor_mma_sequencer.sv
// Issue-side initiator that runs one warp MMA through NUM_PASS tensor-core
// passes, chaining each pass result into the next pass's accumulator.
module tensor_mma_sequencer
  import tensor_mma_sequencer_pkg::*;
#(
  parameter int VL        = NUM_THREAD,
  parameter int NUM_PASS  = 2,
  parameter int EXPWIDTH  = EXPWIDTH_DEFAULT,
  parameter int PRECISION = PRECISION_DEFAULT
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         in_valid_i,
  output logic                                         in_ready_o,
  input  logic [NUM_PASS*VL*fp_width(EXPWIDTH,PRECISION)-1:0] a_i,
  input  logic [NUM_PASS*VL*fp_width(EXPWIDTH,PRECISION)-1:0] b_i,
  input  logic [VL*fp_width(EXPWIDTH,PRECISION)-1:0]   c_i,
  input  logic [2:0]                                   rm_i,
  input  logic [7:0]                                   ctrl_reg_idxw_i,
  input  logic [DEPTH_WARP-1:0]                        ctrl_warpid_i,
  output logic                                         tc_in_valid_o,
  input  logic                                         tc_in_ready_i,
  output logic [VL*fp_width(EXPWIDTH,PRECISION)-1:0]   tc_a_o,
  output logic [VL*fp_width(EXPWIDTH,PRECISION)-1:0]   tc_b_o,
  output logic [VL*fp_width(EXPWIDTH,PRECISION)-1:0]   tc_c_o,
  output logic [VL*3-1:0]                              tc_rm_o,
  output logic [7:0]                                   tc_reg_idxw_o,
  output logic [DEPTH_WARP-1:0]                        tc_warpid_o,
  input  logic                                         tc_out_valid_i,
  output logic                                         tc_out_ready_o,
  input  logic [VL*fp_width(EXPWIDTH,PRECISION)-1:0]   tc_result_i,
  input  logic [VL*5-1:0]                              tc_fflags_i,
  output logic                                         out_valid_o,
  input  logic                                         out_ready_i,
  output logic [VL*fp_width(EXPWIDTH,PRECISION)-1:0]   result_o,
  output logic [VL*5-1:0]                              fflags_o,
  output logic [7:0]                                   ctrl_reg_idxw_o,
  output logic [DEPTH_WARP-1:0]                        ctrl_warpid_o
);

  localparam int W  = fp_width(EXPWIDTH, PRECISION);
  localparam int SW = VL * W;
  localparam logic [2:0] LAST_PASS = 3'(NUM_PASS - 1);

  seq_state_e              r_state;
  logic [2:0]              r_pass_cnt;
  logic [NUM_PASS*SW-1:0]  r_a;
  logic [NUM_PASS*SW-1:0]  r_b;
  logic [SW-1:0]           r_acc;
  logic [VL*5-1:0]         r_fflags;
  logic [2:0]              r_rm;
  logic [7:0]              r_reg_idxw;
  logic [DEPTH_WARP-1:0]   r_warpid;

  logic [SW-1:0]           w_a_slice;
  logic [SW-1:0]           w_b_slice;

  // Passes run strictly back to back: pass p+1 cannot issue until result p
  // has been folded into the accumulator.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_pass_cnt <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_acc      <= '0;
      r_fflags   <= '0;
      r_rm       <= '0;
      r_reg_idxw <= '0;
      r_warpid   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid_i) begin
            r_a        <= a_i;
            r_b        <= b_i;
            r_rm       <= rm_i;
            r_reg_idxw <= ctrl_reg_idxw_i;
            r_warpid   <= ctrl_warpid_i;
            r_acc      <= c_i;
            r_fflags   <= '0;
            r_pass_cnt <= '0;
            r_state    <= ISSUE;
          end
        end
        ISSUE: begin
          if (tc_in_ready_i) begin
            r_state <= WAIT;
          end
        end
        WAIT: begin
          if (tc_out_valid_i) begin
            r_acc    <= tc_result_i;
            r_fflags <= r_fflags | tc_fflags_i;
            if (r_pass_cnt == LAST_PASS) begin
              r_state <= DONE;
            end else begin
              r_pass_cnt <= r_pass_cnt + 3'd1;
              r_state    <= ISSUE;
            end
          end
        end
        DONE: begin
          if (out_ready_i) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign w_a_slice = r_a[int'(r_pass_cnt)*SW +: SW];
  assign w_b_slice = r_b[int'(r_pass_cnt)*SW +: SW];

  // in_ready_o is masked by rst so it only rises once reset is released.
  assign in_ready_o     = (r_state == IDLE) && !rst;
  assign tc_in_valid_o  = (r_state == ISSUE);
  assign tc_out_ready_o = (r_state == WAIT);
  assign out_valid_o    = (r_state == DONE);

  assign tc_a_o        = w_a_slice;
  assign tc_b_o        = w_b_slice;
  assign tc_c_o        = r_acc;
  assign tc_rm_o       = {VL{r_rm}};
  assign tc_reg_idxw_o = r_reg_idxw;
  assign tc_warpid_o   = r_warpid;

  assign result_o        = r_acc;
  assign fflags_o        = r_fflags;
  assign ctrl_reg_idxw_o = r_reg_idxw;
  assign ctrl_warpid_o   = r_warpid;

endmodule
